// File: rtl/conv_window_loader_2x2.sv
// conv_window_loader_2x2
// Byte-stream front end for the 2x2, 3-channel conv core. It collects a frame of
// filter and image bytes, drives them onto the core's buses, waits out the core
// pipeline, captures the 4x16 result and offers it on a valid/ready port.
// Optional feature macro: CONV_LOADER_KEEP_FILTER_EN adds the keep_filter input,
// which lets a frame reuse the previous filter and carry only image bytes.
// Assumes N_IMG >= 2 and CONV_LAT >= 1.
module conv_window_loader_2x2 #(
    parameter int CONV_LAT = 2,
    parameter int N_FILT   = 12,
    parameter int N_IMG    = 30
) (
    input  logic         clk_spi,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [95:0]  filter_bus,
    output logic [239:0] image_bus,
    input  logic [63:0]  conv_in,
    output logic [63:0]  res_data,
    output logic         res_valid,
    input  logic         res_ready,
`ifdef CONV_LOADER_KEEP_FILTER_EN
    input  logic         keep_filter,
`endif
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FILT = 3'd1,
        S_IMG  = 3'd2,
        S_WAIT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [5:0] FILT_LAST = 6'(N_FILT - 1);
    localparam logic [5:0] IMG_LAST  = 6'(N_IMG - 1);
    // conv_in reflects the settled buses CONV_LAT edges after the last byte,
    // so it is sampled on the edge after that.
    localparam logic [7:0] LAT_CNT   = 8'(CONV_LAT);

    state_t         state_q;
    logic [5:0]     idx_q;
    logic [7:0]     wait_q;
    logic [95:0]    filter_q;
    logic [239:0]   image_q;
    logic [63:0]    res_data_q;
    logic           res_valid_q;
    logic           in_ready_q;
    logic           busy_q;
    logic           accept_s;
    logic           keep_s;

`ifdef CONV_LOADER_KEEP_FILTER_EN
    assign keep_s = keep_filter;
`else
    assign keep_s = 1'b0;
`endif

    assign accept_s   = in_valid & in_ready_q;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign filter_bus = filter_q;
    assign image_bus  = image_q;
    assign res_data   = res_data_q;
    assign res_valid  = res_valid_q;

    // Frame FSM: byte assembly, core-latency wait, result hand-off; all outputs registered.
    always_ff @(posedge clk_spi or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= 6'd0;
            wait_q      <= 8'd0;
            filter_q    <= 96'd0;
            image_q     <= 240'd0;
            res_data_q  <= 64'd0;
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept_s) begin
                        busy_q <= 1'b1;
                        if (keep_s) begin
                            image_q[7:0] <= in_data;
                            idx_q        <= 6'd1;
                            state_q      <= S_IMG;
                        end else if (N_FILT == 1) begin
                            filter_q[7:0] <= in_data;
                            idx_q         <= 6'd0;
                            state_q       <= S_IMG;
                        end else begin
                            filter_q[7:0] <= in_data;
                            idx_q         <= 6'd1;
                            state_q       <= S_FILT;
                        end
                    end
                end
                S_FILT: begin
                    if (accept_s) begin
                        filter_q[{idx_q, 3'b000} +: 8] <= in_data;
                        if (idx_q == FILT_LAST) begin
                            idx_q   <= 6'd0;
                            state_q <= S_IMG;
                        end else begin
                            idx_q <= idx_q + 6'd1;
                        end
                    end
                end
                S_IMG: begin
                    if (accept_s) begin
                        image_q[{idx_q, 3'b000} +: 8] <= in_data;
                        if (idx_q == IMG_LAST) begin
                            idx_q      <= 6'd0;
                            wait_q     <= 8'd0;
                            in_ready_q <= 1'b0;
                            state_q    <= S_WAIT;
                        end else begin
                            idx_q <= idx_q + 6'd1;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_q == LAT_CNT) begin
                        res_data_q  <= conv_in;
                        res_valid_q <= 1'b1;
                        wait_q      <= 8'd0;
                        state_q     <= S_DONE;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    idx_q       <= 6'd0;
                    wait_q      <= 8'd0;
                    res_valid_q <= 1'b0;
                    in_ready_q  <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_window_loader_2x2.sv
// Scoreboard bench for conv_window_loader_2x2 with a behavioural conv core model.
module tb_conv_window_loader_2x2;

    localparam int LAT = 2;
    localparam logic [63:0] ONES_RES = 64'h000C_000C_000C_000C;
    localparam logic [63:0] MAP_RES  = 64'h0000_0000_0000_000F;
    localparam logic [63:0] RAMP_RES = 64'h0036_002A_001E_0012;
    localparam logic [63:0] TWOS_RES = 64'h0018_0018_0018_0018;

    logic         clk_spi = 1'b0;
    logic         rst = 1'b0;
    logic [7:0]   in_data = 8'd0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [95:0]  filter_bus;
    logic [239:0] image_bus;
    logic [63:0]  conv_in;
    logic [63:0]  res_data;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic         busy;
`ifdef CONV_LOADER_KEEP_FILTER_EN
    logic         keep_filter = 1'b0;
`endif

    typedef struct {
        logic [63:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_acc = 0;
    int acc_count = 0;
    logic [7:0]   filt_a [12];
    logic [7:0]   img_a  [30];
    logic [95:0]  exp_filt = 96'd0;
    logic [239:0] exp_img = 240'd0;
    logic [63:0]  pipe [LAT];

    conv_window_loader_2x2 #(.CONV_LAT(LAT), .N_FILT(12), .N_IMG(30)) dut (
        .clk_spi    (clk_spi),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .filter_bus (filter_bus),
        .image_bus  (image_bus),
        .conv_in    (conv_in),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
`ifdef CONV_LOADER_KEEP_FILTER_EN
        .keep_filter(keep_filter),
`endif
        .busy       (busy)
    );

    always #5 clk_spi = ~clk_spi;

    always @(posedge clk_spi) cyc <= cyc + 1;

    // 2x2x3 window MAC at four horizontal offsets, 16b wrapping lanes
    function automatic logic [63:0] core_f(input logic [95:0] f, input logic [239:0] im);
        logic [63:0] r;
        logic [15:0] acc;
        r = 64'd0;
        for (int k = 0; k < 4; k++) begin
            acc = 16'd0;
            for (int c = 0; c < 3; c++)
                for (int rw = 0; rw < 2; rw++)
                    for (int col = 0; col < 2; col++)
                        acc = acc + 16'(f[8*(c*4 + rw*2 + col) +: 8]) *
                                    16'(im[8*(c*10 + rw*5 + col + k) +: 8]);
            r[16*k +: 16] = acc;
        end
        return r;
    endfunction

    // core pipeline: result of the buses appears LAT edges later
    always @(posedge clk_spi) begin
        pipe[0] <= core_f(filter_bus, image_bus);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign conv_in = pipe[LAT-1];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: each rising res_valid pops one scoreboard entry
    initial begin : monitor
        logic rv_prev;
        exp_t e;
        rv_prev = 1'b0;
        forever begin
            @(negedge clk_spi);
            if (res_valid === 1'b1 && rv_prev !== 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %0h with empty scoreboard", res_data);
                end else begin
                    e = sb.pop_front();
                    chk("res_data", 256'(res_data), 256'(e.data));
                    chk("res_latency", 256'(cyc), 256'(e.cyc));
                end
            end
            rv_prev = res_valid;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk_spi);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout: got %b expected 1", in_ready);
            in_valid = 1'b0;
        end else begin
            @(negedge clk_spi);
            in_valid = 1'b0;
            last_acc = cyc;
            acc_count++;
        end
    endtask

    task automatic send_frame(input int n_img, input int stall_after, input bit keep,
                              input logic [63:0] exp_res);
        exp_t e;
`ifdef CONV_LOADER_KEEP_FILTER_EN
        keep_filter = keep;
`endif
        if (!keep) begin
            for (int i = 0; i < 12; i++) begin
                send_byte(filt_a[i]);
                exp_filt[8*i +: 8] = filt_a[i];
`ifdef CONV_LOADER_KEEP_FILTER_EN
                keep_filter = 1'b0;
`endif
            end
        end
        for (int i = 0; i < n_img; i++) begin
            send_byte(img_a[i]);
            exp_img[8*i +: 8] = img_a[i];
`ifdef CONV_LOADER_KEEP_FILTER_EN
            keep_filter = 1'b0;
`endif
            if (i == stall_after) begin
                repeat (7) begin
                    @(negedge clk_spi);
                    chk("stall_in_ready", 256'(in_ready), 256'(1'b1));
                    chk("stall_busy", 256'(busy), 256'(1'b1));
                    chk("stall_image_bus", 256'(image_bus), 256'(exp_img));
                end
            end
        end
        if (n_img == 30) begin
            e.data = exp_res;
            e.cyc  = last_acc + LAT + 1;
            sb.push_back(e);
            chk("filter_bus", 256'(filter_bus), 256'(exp_filt));
            chk("image_bus", 256'(image_bus), 256'(exp_img));
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 200) begin
            @(negedge clk_spi);
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: busy=%b pending=%0d expected idle", busy, sb.size());
        end
    endtask

    task automatic fill(input logic [7:0] fv, input logic [7:0] iv);
        for (int i = 0; i < 12; i++) filt_a[i] = fv;
        for (int i = 0; i < 30; i++) img_a[i] = iv;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        #2 rst = 1'b1;
        repeat (3) @(negedge clk_spi);
        chk("rst_filter_bus", 256'(filter_bus), 256'(96'd0));
        chk("rst_image_bus", 256'(image_bus), 256'(240'd0));
        chk("rst_res_data", 256'(res_data), 256'(64'd0));
        chk("rst_res_valid", 256'(res_valid), 256'(1'b0));
        chk("rst_busy", 256'(busy), 256'(1'b0));
        chk("rst_in_ready", 256'(in_ready), 256'(1'b0));
        rst = 1'b0;
        #1 chk("rel_in_ready_low", 256'(in_ready), 256'(1'b0));
        @(negedge clk_spi);
        chk("rel_in_ready_high", 256'(in_ready), 256'(1'b1));

        // 1: ones frame
        fill(8'h01, 8'h01);
        send_frame(30, -1, 1'b0, ONES_RES);
        wait_idle();

        // 2: byte map
        fill(8'h00, 8'h00);
        filt_a[0] = 8'h05;
        img_a[0]  = 8'h03;
        send_frame(30, -1, 1'b0, MAP_RES);
        wait_idle();
        chk("map_filter_b0", 256'(filter_bus[7:0]), 256'(8'h05));
        chk("map_image_b0", 256'(image_bus[7:0]), 256'(8'h03));
        chk("retain_filter_bus", 256'(filter_bus), 256'(exp_filt));

        // 3: backpressure
        res_ready = 1'b0;
        fill(8'h01, 8'h01);
        send_frame(30, -1, 1'b0, ONES_RES);
        n = 0;
        while (res_valid !== 1'b1 && n < 50) begin
            @(negedge clk_spi);
            n++;
        end
        repeat (10) begin
            @(negedge clk_spi);
            chk("bp_res_valid", 256'(res_valid), 256'(1'b1));
            chk("bp_res_data", 256'(res_data), 256'(ONES_RES));
            chk("bp_in_ready", 256'(in_ready), 256'(1'b0));
            chk("bp_busy", 256'(busy), 256'(1'b1));
        end
        res_ready = 1'b1;
        @(negedge clk_spi);
        chk("bp_release_valid", 256'(res_valid), 256'(1'b0));
        chk("bp_release_busy", 256'(busy), 256'(1'b0));
        chk("bp_release_in_ready", 256'(in_ready), 256'(1'b1));

        // 4: ramp image, unstalled then stalled after image byte 8 (frame byte 20)
        fill(8'h01, 8'h00);
        for (int i = 0; i < 30; i++) img_a[i] = 8'((i % 5) + 1);
        send_frame(30, -1, 1'b0, RAMP_RES);
        wait_idle();
        send_frame(30, 8, 1'b0, RAMP_RES);
        wait_idle();

        // 5: reset after 5 image bytes
        fill(8'h01, 8'h01);
        send_frame(5, -1, 1'b0, 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_filter_bus", 256'(filter_bus), 256'(96'd0));
        chk("mid_rst_image_bus", 256'(image_bus), 256'(240'd0));
        chk("mid_rst_res_valid", 256'(res_valid), 256'(1'b0));
        chk("mid_rst_busy", 256'(busy), 256'(1'b0));
        exp_filt = 96'd0;
        exp_img  = 240'd0;
        repeat (2) @(negedge clk_spi);
        rst = 1'b0;
        @(negedge clk_spi);
        send_frame(30, -1, 1'b0, ONES_RES);
        wait_idle();

`ifdef CONV_LOADER_KEEP_FILTER_EN
        // 6: keep the ones filter, image of twos
        fill(8'h01, 8'h02);
        acc_count = 0;
        send_frame(30, -1, 1'b1, TWOS_RES);
        wait_idle();
        chk("keep_byte_count", 256'(acc_count), 256'(30));
        chk("keep_filter_bus", 256'(filter_bus), 256'({12{8'h01}}));
`endif

        repeat (5) @(negedge clk_spi);
        chk("scoreboard_drained", 256'(sb.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
